// File: rtl/scatter_sched.sv
// scatter_sched: phase controller for one charge-deposit pass (CLEAR -> SCATTER -> DRAIN -> DONE).
// Define SCATTER_SCHED_PERF_EN to add the stall_cycles / pass_cycles performance counters.
module scatter_sched #(
    parameter int ADDR_W     = 16,
    parameter int GRID_DEPTH = 4096,
    parameter int PIPE_LAT   = 9,
    parameter int NPART_W    = 20,
    parameter int POS_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NPART_W-1:0] num_particles,
    input  logic               part_valid,
    output logic               part_ready,
    input  logic [POS_W-1:0]   part_gyro,
    output logic               acc_valid,
    output logic [POS_W-1:0]   acc_gyro,
    output logic               clr_we,
    output logic [ADDR_W-1:0]  clr_addr,
    output logic               grid_sel_clear,
    output logic               busy,
    output logic               done,
    output logic [NPART_W-1:0] accepted
`ifdef SCATTER_SCHED_PERF_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        pass_cycles
`endif
);

    localparam int                 DRAIN_W    = $clog2(PIPE_LAT + 2);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(GRID_DEPTH - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SCATTER, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NPART_W-1:0] target;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               xfer;

    always_comb begin
        state_nxt      = state;
        part_ready     = 1'b0;
        clr_we         = 1'b0;
        grid_sel_clear = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        xfer           = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                clr_we         = 1'b1;
                grid_sel_clear = 1'b1;
                busy           = 1'b1;
                if (clr_addr == LAST_ADDR) state_nxt = SCATTER;
            end
            SCATTER: begin
                busy       = 1'b1;
                part_ready = (accepted < target);
                xfer       = part_ready & part_valid;
                // Leave on the beat that reaches target; a zero target leaves after one idle cycle.
                if ((accepted == target) || (xfer && (accepted + NPART_W'(1) == target)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            target    <= '0;
            accepted  <= '0;
            clr_addr  <= '0;
            drain_cnt <= '0;
            acc_valid <= 1'b0;
            acc_gyro  <= '0;
        end else begin
            state     <= state_nxt;
            acc_valid <= xfer;
            if (xfer) begin
                acc_gyro <= part_gyro;
                accepted <= accepted + NPART_W'(1);
            end
            if ((state == IDLE) && start) begin
                target   <= num_particles;
                accepted <= '0;
            end
            if (state == CLEAR)
                clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + ADDR_W'(1);
            // Drain spans the output register beat plus the accumulator pipeline.
            if ((state != DRAIN) && (state_nxt == DRAIN))
                drain_cnt <= DRAIN_LOAD;
            else if (state == DRAIN)
                drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end

`ifdef SCATTER_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            pass_cycles  <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
            pass_cycles  <= '0;
        end else begin
            if (part_ready && !part_valid && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (busy && (pass_cycles != 32'hFFFF_FFFF))
                pass_cycles <= pass_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scatter_sched.sv
// tb_scatter_sched: table vectors plus randomized passes checked against a timeline model of one pass.
// Honours SCATTER_SCHED_PERF_EN to also check the performance counters.
module tb_scatter_sched;

    localparam int ADDR_W   = 16;
    localparam int GRID     = 128;
    localparam int PIPE_LAT = 9;
    localparam int NPART_W  = 20;
    localparam int POS_W    = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic [NPART_W-1:0] num_particles;
    logic               part_valid;
    logic               part_ready;
    logic [POS_W-1:0]   part_gyro;
    logic               acc_valid;
    logic [POS_W-1:0]   acc_gyro;
    logic               clr_we;
    logic [ADDR_W-1:0]  clr_addr;
    logic               grid_sel_clear;
    logic               busy;
    logic               done;
    logic [NPART_W-1:0] accepted;
`ifdef SCATTER_SCHED_PERF_EN
    logic [31:0]        stall_cycles;
    logic [31:0]        pass_cycles;
`endif

    scatter_sched #(
        .ADDR_W(ADDR_W), .GRID_DEPTH(GRID), .PIPE_LAT(PIPE_LAT),
        .NPART_W(NPART_W), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_particles(num_particles),
        .part_valid(part_valid), .part_ready(part_ready), .part_gyro(part_gyro),
        .acc_valid(acc_valid), .acc_gyro(acc_gyro), .clr_we(clr_we), .clr_addr(clr_addr),
        .grid_sel_clear(grid_sel_clear), .busy(busy), .done(done), .accepted(accepted)
`ifdef SCATTER_SCHED_PERF_EN
        , .stall_cycles(stall_cycles), .pass_cycles(pass_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pass timeline model: clear window, scatter end cycle, done cycle derived from it.
    int          cyc = 0;
    bit          in_pass = 0;
    int          s_cyc = 0;
    int          e_cyc = -1;
    int          tgt = 0;
    int          acc_cnt = 0;
    bit          accv_q = 0;
    logic [31:0] gyro_q = '0;
    longint      stall_m = 0;
    longint      pass_m = 0;
    int          beats = 0;
    bit          done_seen = 0;

    typedef struct {
        int          np;
        logic [15:0] mask;
        int          exp_acc;
        int          exp_beats;
        int          exp_stall;
    } vec_t;

    vec_t vecs[5];

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit scatter_now();
        return in_pass && (cyc > s_cyc + GRID) && (e_cyc < 0);
    endfunction

    task automatic model_reset();
        in_pass = 0; e_cyc = -1; tgt = 0; acc_cnt = 0;
        accv_q = 0; gyro_q = '0; stall_m = 0; pass_m = 0;
    endtask

    // Compare this cycle's outputs against the model, then advance the model over the coming edge.
    task automatic checkOutput(input logic st, input int np, input logic pv, input logic [31:0] pg);
        bit exp_ready = 0, exp_we = 0, exp_sel = 0, exp_busy = 0, exp_done = 0;
        bit in_scatter = 0, finishing = 0, xfer;
        int exp_addr = 0;
        if (in_pass) begin
            if (cyc <= s_cyc + GRID) begin
                exp_we = 1; exp_sel = 1; exp_busy = 1; exp_addr = cyc - s_cyc - 1;
            end else if (e_cyc < 0) begin
                in_scatter = 1; exp_busy = 1; exp_ready = (acc_cnt < tgt);
            end else if (cyc <= e_cyc + PIPE_LAT + 1) begin
                exp_busy = 1;
            end else begin
                exp_done = 1; finishing = 1;
            end
        end
        check_val("outputs",
            {part_ready, acc_valid, acc_gyro, clr_we, clr_addr, grid_sel_clear, busy, done, accepted},
            {exp_ready, accv_q, gyro_q, exp_we, ADDR_W'(exp_addr), exp_sel, exp_busy, exp_done,
             NPART_W'(acc_cnt)});
`ifdef SCATTER_SCHED_PERF_EN
        check_val("stall_cycles", stall_cycles, 32'(stall_m));
        check_val("pass_cycles", pass_cycles, 32'(pass_m));
`endif
        if (acc_valid === 1'b1) beats++;
        xfer = in_scatter && exp_ready && pv;
        if (in_scatter && exp_ready && !pv) stall_m++;
        if (exp_busy) pass_m++;
        accv_q = xfer;
        if (xfer) begin
            gyro_q = pg;
            acc_cnt++;
        end
        if (in_scatter && (acc_cnt == tgt)) e_cyc = cyc;
        if (finishing) begin
            in_pass = 0; done_seen = 1;
        end else if (!in_pass && st) begin
            in_pass = 1; s_cyc = cyc; e_cyc = -1; tgt = np; acc_cnt = 0; stall_m = 0; pass_m = 0;
        end
        cyc++;
    endtask

    task automatic applyStimulus(input logic st, input int np, input logic pv, input logic [31:0] pg);
        @(negedge clk);
        start = st; num_particles = NPART_W'(np); part_valid = pv; part_gyro = pg;
        #1;
        checkOutput(st, np, pv, pg);
    endtask

    task automatic check_zero(input string name);
        check_val(name,
            {part_ready, acc_valid, acc_gyro, clr_we, clr_addr, grid_sel_clear, busy, done, accepted},
            '0);
`ifdef SCATTER_SCHED_PERF_EN
        check_val({name, "_perf"}, {stall_cycles, pass_cycles}, '0);
`endif
    endtask

    // One pass: start, then drive until the model sees done; mask selects valid per scatter cycle.
    task automatic run_pass(input int np, input logic [15:0] mask, input bit rand_valid, input bit poke);
        int   k = 0;
        int   guard = 0;
        logic pv;
        beats = 0; done_seen = 0;
        applyStimulus(1'b1, np, 1'($urandom % 2), $urandom);
        while (!done_seen && guard < GRID + 300) begin
            if (scatter_now()) begin
                pv = rand_valid ? 1'($urandom % 2) : mask[k % 16];
                k++;
            end else begin
                pv = 1'($urandom % 2);
            end
            applyStimulus((poke && k == 2) ? 1'b1 : 1'b0, poke ? 7 : np, pv, $urandom);
            guard++;
        end
        if (!done_seen) check_val("pass_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{np: 4, mask: 16'hFFFF, exp_acc: 4, exp_beats: 4, exp_stall: 0};
        vecs[1] = '{np: 3, mask: 16'h0019, exp_acc: 3, exp_beats: 3, exp_stall: 2};
        vecs[2] = '{np: 0, mask: 16'hFFFF, exp_acc: 0, exp_beats: 0, exp_stall: 0};
        vecs[3] = '{np: 5, mask: 16'h5555, exp_acc: 5, exp_beats: 5, exp_stall: 4};
        vecs[4] = '{np: 2, mask: 16'h0006, exp_acc: 2, exp_beats: 2, exp_stall: 1};

        rst = 1'b0; start = 1'b0; num_particles = '0; part_valid = 1'b0; part_gyro = '0;
        @(negedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_pass(vecs[i].np, vecs[i].mask, 1'b0, 1'b0);
            check_val("vec_accepted", accepted, NPART_W'(vecs[i].exp_acc));
            check_val("vec_beats", beats, vecs[i].exp_beats);
`ifdef SCATTER_SCHED_PERF_EN
            check_val("vec_stall", stall_cycles, vecs[i].exp_stall);
`endif
        end

        // Reset in the middle of CLEAR, at clr_addr = 100.
        applyStimulus(1'b1, 6, 1'b0, $urandom);
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 6, 1'b1, $urandom);
        @(negedge clk);
        check_val("clr_addr_before_rst", clr_addr, 100);
        start = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("midpass_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_pass(2, 16'hFFFF, 1'b0, 1'b0);
        check_val("after_reset_accepted", accepted, 2);

        // start pulsed during SCATTER with a different count must be ignored.
        applyStimulus(1'b0, 0, 1'b0, $urandom);
        run_pass(3, 16'h0019, 1'b0, 1'b1);
        check_val("poke_accepted", accepted, 3);
        check_val("poke_beats", beats, 3);

        // Randomized passes, back-to-back or separated by idle cycles.
        for (int i = 0; i < 8; i++) begin
            int np;
            np = int'($urandom_range(0, 6));
            run_pass(np, 16'h0000, 1'b1, 1'b0);
            check_val("rand_accepted", accepted, NPART_W'(np));
            check_val("rand_beats", beats, np);
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 0, 1'($urandom % 2), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scatter_sched.md
Name: scatter_sched

Overview:
- Phase controller for one charge-deposit pass on the charge grid.
- Sequence per pass:
  - CLEAR: zero every grid cell through the grid write port.
  - SCATTER: stream a programmed number of gyropoints from the pusher into the accumulator, using a valid/ready handshake.
  - DRAIN: wait out the accumulator pipeline.
  - DONE: signal completion to the field solver.
- Placement: between the particle pusher and the accumulator; owns the grid write-port select.

Parameters:
- ADDR_W, 16, grid address width ({y.whole, x.whole}).
- GRID_DEPTH, 4096, number of grid cells cleared per pass.
- PIPE_LAT, 9, cycles from accumulator valid_in to its last write of that point.
- NPART_W, 20, width of the particle-count registers.
- POS_W, 32, width of posvec_t.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- num_particles  in  NPART_W  points to scatter this pass; latched on start
- part_valid  in  1  pusher has a gyropoint
- part_ready  out  1  scheduler accepts the gyropoint this cycle
- part_gyro  in  POS_W  gyropoint from pusher
- acc_valid  out  1  valid_in to accumulator
- acc_gyro  out  POS_W  gyropoint to accumulator
- clr_we  out  1  grid write enable for clear
- clr_addr  out  ADDR_W  grid clear address
- grid_sel_clear  out  1  1 = grid write port driven by clr_*; 0 = by accumulator
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when the pass completes
- accepted  out  NPART_W  points accepted this pass

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0: part_ready, acc_valid, acc_gyro, clr_we, clr_addr, grid_sel_clear, busy, done, accepted. Internal counters also 0.
- IDLE:
  - start=1 latches num_particles, clears accepted, sets busy=1 and goes to CLEAR next cycle.
  - start is ignored in every other state.
- CLEAR:
  - grid_sel_clear=1 and clr_we=1.
  - clr_addr counts 0..GRID_DEPTH-1, one cell per cycle.
  - After the cycle with clr_addr=GRID_DEPTH-1: clr_we=0, clr_addr returns to 0, go to SCATTER.
  - Duration: exactly GRID_DEPTH cycles.
- SCATTER:
  - grid_sel_clear=0.
  - part_ready=1 while accepted < target (combinational from state and counter).
  - Transfer occurs on part_valid & part_ready. On a transfer, acc_valid=1 and acc_gyro=part_gyro on the next cycle (1-cycle registered latency), and accepted increments.
  - No transfer: acc_valid=0 and acc_gyro holds its value.
  - When accepted reaches target, part_ready drops in the same cycle the count updates; go to DRAIN.
- num_particles=0: CLEAR → SCATTER for one cycle with part_ready=0 → DRAIN.
- DRAIN:
  - A drain counter loads PIPE_LAT+1 on entry and decrements each cycle. This covers the 1-cycle output register plus the accumulator pipeline.
  - At 0, go to DONE.
  - part_ready=0 and acc_valid=0 throughout, after the final registered beat.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Back-to-back passes: start asserted in the cycle after DONE is honoured.
- Counters never wrap. accepted saturates at target by construction. clr_addr is compared against GRID_DEPTH-1, not against an overflow.
- Reset mid-pass: all state discarded immediately, no done pulse. Partially cleared or scattered grid contents are undefined; software reruns the pass.
- part_valid held while part_ready=0: no transfer, and part_gyro is not sampled.

Optional Feature:
- Macro: SCATTER_SCHED_PERF_EN.
- When defined:
  - Adds output stall_cycles (32-bit): counts SCATTER cycles with part_ready=1 and part_valid=0.
  - Adds output pass_cycles (32-bit): counts every cycle with busy=1.
  - Both clear on start in IDLE and on reset, hold after DONE, and saturate at 32'hFFFF_FFFF.
- When undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset while in CLEAR at clr_addr=100 → all outputs 0 next sample, state IDLE. A new start then clears from address 0.
- GRID_DEPTH=16, num_particles=4, part_valid held 1 → clr_we high 16 cycles (addr 0..15). Then 4 consecutive acc_valid beats carrying the supplied gyropoints, done exactly PIPE_LAT+1 cycles after the last acc_valid, accepted=4.
- num_particles=3, part_valid pattern 1,0,0,1,1 → exactly 3 transfers, acc_valid mirrors transfers one cycle later, stall count 2 (with SCATTER_SCHED_PERF_EN).
- num_particles=0 → CLEAR completes, no acc_valid ever asserts, done pulses, accepted=0.
- start pulsed during SCATTER → ignored: num_particles not re-latched, accepted continues to its original target.
- start asserted in the cycle after done → second pass begins: busy=1 next cycle, clr_addr restarts at 0.
